// File: rtl/ahb_master_pkg.sv
// Shared AHB encodings and the copy-engine state type.
package ahb_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_WR_A,
        ST_WR_D,
        ST_RESP2,
        ST_FIN
    } state_e;

endpackage

// File: rtl/ahb_boot_copy_master.sv
// AHB initiator copying word_count 32-bit words from src_addr to dst_addr,
// one SINGLE read followed by one SINGLE write per word.
module ahb_boot_copy_master
    import ahb_master_pkg::*;
#(
    parameter int         CNT_W     = 10,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic             hclk,
    input  logic             n_hreset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_done,
    output logic             hbusreq,
    input  logic             hgrant,
    output logic [31:0]      haddr,
    output logic [1:0]       htrans,
    output logic             hwrite,
    output logic [2:0]       hsize,
    output logic [2:0]       hburst,
    output logic [3:0]       hprot,
    output logic             hmastlock,
    output logic [31:0]      hwdata,
    input  logic [31:0]      hrdata,
    input  logic             hready,
    input  logic [1:0]       hresp
);

    state_e           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] words_done_q, words_done_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic             hwrite_q, hwrite_d;
    logic             busy_q, busy_d;
    logic             hbusreq_q, hbusreq_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Byte-lane bits of the job addresses are discarded by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        cnt_d        = cnt_q;
        words_done_d = words_done_q;
        buf_d        = buf_q;
        haddr_d      = haddr_q;
        hwdata_d     = hwdata_q;
        hwrite_d     = hwrite_q;
        busy_d       = busy_q;
        hbusreq_d    = hbusreq_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d        = 1'b0;
                    words_done_d = '0;
                    if (word_count == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        src_ptr_d = {src_addr[31:2], 2'b00};
                        dst_ptr_d = {dst_addr[31:2], 2'b00};
                        cnt_d     = word_count;
                        busy_d    = 1'b1;
                        hbusreq_d = 1'b1;
                        state_d   = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                if (hgrant && hready) state_d = ST_RD_D;
            end
            ST_RD_D: begin
                if (hready) begin
                    if (hresp == HRESP_OKAY) begin
                        buf_d   = hrdata;
                        state_d = ST_WR_A;
                    end else if (hresp == HRESP_ERROR) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end else if (hresp != HRESP_OKAY) begin
                    state_d = ST_RESP2;
                end
            end
            ST_WR_A: begin
                if (hgrant && hready) state_d = ST_WR_D;
            end
            ST_WR_D: begin
                if (hready) begin
                    if (hresp == HRESP_OKAY) begin
                        words_done_d = words_done_q + 1'b1;
                        src_ptr_d    = src_ptr_q + 32'd4;
                        dst_ptr_d    = dst_ptr_q + 32'd4;
                        cnt_d        = cnt_q - 1'b1;
                        state_d      = (cnt_q == CNT_W'(1)) ? ST_FIN : ST_RD_A;
                    end else if (hresp == HRESP_ERROR) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_WR_A;
                    end
                end else if (hresp != HRESP_OKAY) begin
                    state_d = ST_RESP2;
                end
            end
            ST_RESP2: begin
                // hwrite_q still identifies which half of the word failed.
                if (hready) begin
                    if (hresp == HRESP_ERROR) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d = hwrite_q ? ST_WR_A : ST_RD_A;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_RD_A) begin
            haddr_d  = src_ptr_d;
            hwrite_d = 1'b0;
        end else if (state_d == ST_WR_A) begin
            haddr_d  = dst_ptr_d;
            hwrite_d = 1'b1;
        end

        if (state_q == ST_WR_A && state_d == ST_WR_D) hwdata_d = buf_q;

        done_d = (state_d == ST_FIN);
        if (state_d == ST_FIN) begin
            busy_d    = 1'b0;
            hbusreq_d = 1'b0;
        end
    end

    always_ff @(posedge hclk) begin
        if (!n_hreset) begin
            state_q      <= ST_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            cnt_q        <= '0;
            words_done_q <= '0;
            buf_q        <= '0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            hwrite_q     <= 1'b0;
            busy_q       <= 1'b0;
            hbusreq_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            cnt_q        <= cnt_d;
            words_done_q <= words_done_d;
            buf_q        <= buf_d;
            haddr_q      <= haddr_d;
            hwdata_q     <= hwdata_d;
            hwrite_q     <= hwrite_d;
            busy_q       <= busy_d;
            hbusreq_q    <= hbusreq_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // NONSEQ only while an address state actually owns the bus.
    assign htrans = ((state_q == ST_RD_A || state_q == ST_WR_A) && hgrant)
                    ? HTRANS_NONSEQ : HTRANS_IDLE;

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = words_done_q;
    assign hbusreq    = hbusreq_q;
    assign haddr      = haddr_q;
    assign hwrite     = hwrite_q;
    assign hwdata     = hwdata_q;
    assign hsize      = HSIZE_WORD;
    assign hburst     = HBURST_SINGLE;
    assign hprot      = HPROT_VAL;
    assign hmastlock  = 1'b0;

endmodule

// File: tb/tb_ahb_boot_copy_master.sv
// Bench for ahb_boot_copy_master: AHB slave/ROM/SRAM model plus a transfer scoreboard.
module tb_ahb_boot_copy_master;
    import ahb_master_pkg::*;

    localparam int CNT_W = 10;

    logic             hclk = 1'b0;
    logic             n_hreset = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [CNT_W-1:0] word_count = '0;
    logic             busy, done, err, hbusreq, hwrite, hmastlock;
    logic [CNT_W-1:0] words_done;
    logic [31:0]      haddr, hwdata;
    logic [1:0]       htrans;
    logic [2:0]       hsize, hburst;
    logic [3:0]       hprot;
    logic             hgrant = 1'b1;
    logic             hready = 1'b1;
    logic [1:0]       hresp = HRESP_OKAY;
    logic [31:0]      hrdata = '0;

    always #5 hclk = ~hclk;

    ahb_boot_copy_master #(.CNT_W(CNT_W), .HPROT_VAL(4'b0011)) dut (
        .hclk(hclk), .n_hreset(n_hreset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [CNT_W-1:0] wd;
        logic             er;
    } done_t;

    xfer_t       exp_q[$];
    done_t       done_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] rom [64];
    logic [31:0] sram[64];

    int cfg_waits = 0, cfg_err_at = -1, cfg_retry_at = -1, cfg_deny_at = -1;
    int deny_left = 0, acc_cnt = 0, done_cyc = 0;
    bit done_seen = 0;

    bit          dp_valid = 0, dp_wr = 0;
    logic [31:0] dp_addr = '0, dp_data = '0;
    int          dp_wait = 0, dp_kind = 0, dp_stage = 0;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave + monitor: drives the response for this cycle, then checks what the
    // DUT presents and pops the scoreboard on every accepted address phase.
    always @(negedge hclk) begin
        xfer_t e;
        done_t d;
        if (!n_hreset) begin
            dp_valid = 0;
            hready   = 1'b1;
            hresp    = HRESP_OKAY;
            hgrant   = 1'b1;
        end else begin
            hgrant = 1'b1;
            if (deny_left > 0 && acc_cnt == cfg_deny_at && !dp_valid) begin
                hgrant = 1'b0;
                deny_left--;
            end
            hready = 1'b1;
            hresp  = HRESP_OKAY;
            if (dp_valid) begin
                if (dp_kind != 0) begin
                    hresp  = (dp_kind == 1) ? HRESP_ERROR : HRESP_RETRY;
                    hready = (dp_stage == 1);
                end else if (dp_wait > 0) begin
                    hready = 1'b0;
                    dp_wait--;
                end
                if (!dp_wr) hrdata = rom[dp_addr[7:2]];
            end
            #1;
            if (dp_valid && dp_wr) chk("hwdata", hwdata, dp_data);
            if (dp_valid && dp_kind != 0 && dp_stage == 1) chk("htrans_resp2", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
            if (!hgrant) chk("htrans_nogrant", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
            if (dp_valid) begin
                if (hready) begin
                    if (dp_wr && dp_kind == 0 && dp_addr[31:28] == 4'h2) sram[dp_addr[7:2]] = hwdata;
                    dp_valid = 0;
                end else if (dp_kind != 0) begin
                    dp_stage = 1;
                end
            end
            if (htrans == HTRANS_NONSEQ && hready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_xfer: got haddr=0x%08h hwrite=%0d required none", haddr, hwrite);
                end else begin
                    e = exp_q.pop_front();
                    chk("haddr", haddr, e.addr);
                    chk("hwrite", {31'd0, hwrite}, {31'd0, e.wr});
                    $display("[TB] xfer %0d %s addr=0x%08h", acc_cnt, e.wr ? "WR" : "RD", haddr);
                    dp_valid = 1;
                    dp_wr    = hwrite;
                    dp_addr  = haddr;
                    dp_data  = e.data;
                    dp_wait  = cfg_waits;
                    dp_stage = 0;
                    dp_kind  = (acc_cnt == cfg_err_at) ? 1 : (acc_cnt == cfg_retry_at) ? 2 : 0;
                    acc_cnt++;
                end
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                if (done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1 required 0");
                end else begin
                    d = done_q.pop_front();
                    chk("done_words", {22'd0, words_done}, {22'd0, d.wd});
                    chk("done_err", {31'd0, err}, {31'd0, d.er});
                end
            end
        end
    end

    task automatic prep_job(input logic [31:0] s, input logic [31:0] dd, input int n,
                            input int waits, input int err_at, input int retry_at,
                            input int deny_at, input int deny_n, output int wd, output bit errd);
        logic [31:0] sp, dpp;
        xfer_t e;
        int a;
        sp  = {s[31:2], 2'b00};
        dpp = {dd[31:2], 2'b00};
        a = 0; wd = 0; errd = 0;
        cfg_waits = waits; cfg_err_at = err_at; cfg_retry_at = retry_at;
        cfg_deny_at = deny_at; deny_left = deny_n; acc_cnt = 0; done_seen = 0;
        for (int i = 0; i < 64; i++) sram[i] = 32'hDEAD_BEEF;
        for (int k = 0; k < n && !errd; k++) begin
            for (int w = 0; w < 2 && !errd; w++) begin
                e.addr = (w == 1) ? dpp : sp;
                e.wr   = (w == 1);
                e.data = rom[sp[7:2]];
                exp_q.push_back(e);
                if (a == retry_at) begin
                    exp_q.push_back(e);
                    a++;
                end
                if (a == err_at) errd = 1;
                a++;
            end
            if (!errd) begin
                wd++;
                sp  = sp + 32'd4;
                dpp = dpp + 32'd4;
            end
        end
        done_q.push_back('{CNT_W'(wd), errd});
    endtask

    task automatic run_job(input string name, input logic [31:0] s, input logic [31:0] dd,
                           input int n, input int waits, input int err_at, input int retry_at,
                           input int deny_at, input int deny_n, input int exp_lat, input bit mid_start);
        int wd, c0;
        bit errd;
        logic [31:0] sp, dpp;
        prep_job(s, dd, n, waits, err_at, retry_at, deny_at, deny_n, wd, errd);
        @(negedge hclk);
        src_addr = s; dst_addr = dd; word_count = CNT_W'(n); start = 1'b1;
        c0 = cyc;
        @(negedge hclk);
        #2;
        start = 1'b0;
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, (n > 0)});
        chk({name, "_hbusreq"}, {31'd0, hbusreq}, {31'd0, (n > 0)});
        for (int t = 0; t < 400 && !done_seen; t++) begin
            if (mid_start && t == 3) begin
                src_addr = 32'h0000_0100; dst_addr = 32'h2000_0020;
                word_count = CNT_W'(5); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge hclk);
            #2;
        end
        start = 1'b0;
        if (!done_seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: got no done required done", name);
        end else begin
            chk({name, "_latency"}, done_cyc - c0, exp_lat);
        end
        repeat (4) @(negedge hclk);
        #2;
        chk({name, "_xfers_left"}, exp_q.size(), 0);
        chk({name, "_done_left"}, done_q.size(), 0);
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({name, "_words_done"}, {22'd0, words_done}, wd);
        chk({name, "_err"}, {31'd0, err}, {31'd0, errd});
        sp  = {s[31:2], 2'b00};
        dpp = {dd[31:2], 2'b00};
        for (int k = 0; k < wd; k++) begin
            chk({name, "_sram"}, sram[dpp[7:2]], rom[sp[7:2]]);
            sp  = sp + 32'd4;
            dpp = dpp + 32'd4;
        end
        $display("[TB] job %s words_done=%0d err=%0d latency=%0d", name, words_done, err, done_cyc - c0);
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic check_reset(input string name);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_done"}, {31'd0, done}, 32'd0);
        chk({name, "_err"}, {31'd0, err}, 32'd0);
        chk({name, "_words_done"}, {22'd0, words_done}, 32'd0);
        chk({name, "_hbusreq"}, {31'd0, hbusreq}, 32'd0);
        chk({name, "_haddr"}, haddr, 32'd0);
        chk({name, "_htrans"}, {30'd0, htrans}, {30'd0, HTRANS_IDLE});
        chk({name, "_hwrite"}, {31'd0, hwrite}, 32'd0);
        chk({name, "_hwdata"}, hwdata, 32'd0);
    endtask

    initial begin
        int wd;
        bit errd;
        for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 + i * 32'h0000_0101;
        repeat (3) @(negedge hclk);
        #2;
        check_reset("rst_init");
        chk("hsize", {29'd0, hsize}, {29'd0, HSIZE_WORD});
        chk("hburst", {29'd0, hburst}, {29'd0, HBURST_SINGLE});
        chk("hprot", {28'd0, hprot}, 32'h3);
        chk("hmastlock", {31'd0, hmastlock}, 32'd0);
        n_hreset = 1'b1;

        run_job("zero_wait", 32'h0000_0000, 32'h2000_0000, 4, 0, -1, -1, -1, 0, 17, 0);
        run_job("wait2",     32'h0000_0000, 32'h2000_0000, 4, 2, -1, -1, -1, 0, 33, 0);
        run_job("nogrant",   32'h0000_0010, 32'h2000_0040, 4, 0, -1, -1,  5, 3, 20, 0);
        run_job("wr_error",  32'h0000_0000, 32'h2000_0000, 4, 0,  5, -1, -1, 0, 14, 0);
        run_job("rd_retry",  32'h0000_0007, 32'h2000_0002, 3, 0, -1,  2, -1, 0, 16, 0);
        run_job("zero_cnt",  32'h0000_0100, 32'h2000_0000, 0, 0, -1, -1, -1, 0,  1, 0);
        run_job("wrap",      32'hFFFF_FFFC, 32'h2000_0080, 2, 0, -1, -1, -1, 0,  9, 0);
        run_job("mid_start", 32'h0000_0020, 32'h2000_0010, 2, 0, -1, -1, -1, 0,  9, 1);

        prep_job(32'h0000_0000, 32'h2000_0000, 4, 0, -1, -1, -1, 0, wd, errd);
        @(negedge hclk);
        src_addr = 32'h0; dst_addr = 32'h2000_0000; word_count = CNT_W'(4); start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        repeat (5) @(negedge hclk);
        n_hreset = 1'b0;
        @(negedge hclk);
        #2;
        check_reset("rst_mid");
        n_hreset = 1'b1;
        exp_q.delete();
        done_q.delete();
        repeat (3) @(negedge hclk);
        #2;
        chk("rst_mid_idle_htrans", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
        chk("rst_mid_idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_boot_copy_master.md
Name: ahb_boot_copy_master

Overview:
- AHB initiator that copies a block of 32-bit words from a source region to a destination region. Typical use: ROM subsystem image into on-chip SRAM at boot.
- Sits on the AHB as a bus master and issues the read transfers that the ROM slave answers.
- Configured and started by a sideband start pulse from the boot controller. Reports busy, done and error status.

Parameters:
- CNT_W, 10, width of word_count and words_done (max 1023 words per job).
- HPROT_VAL, 4'b0011, constant hprot driven on every transfer (data, privileged).

Ports:
- hclk  in  1  AHB clock.
- n_hreset  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; latches src_addr/dst_addr/word_count; ignored while busy.
- src_addr  in  32  source byte address; bits [1:0] ignored (treated 00).
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- word_count  in  CNT_W  number of words to copy.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end (normal or error).
- err  out  1  sticky; set on ERROR response, cleared by next accepted start.
- words_done  out  CNT_W  words fully written in current/last job.
- hbusreq  out  1  bus request.
- hgrant  in  1  bus grant.
- haddr  out  32  address.
- htrans  out  2  IDLE=00 or NONSEQ=10 only.
- hwrite  out  1  write.
- hsize  out  3  constant 3'b010 (word).
- hburst  out  3  constant 3'b000 (SINGLE).
- hprot  out  4  constant HPROT_VAL.
- hmastlock  out  1  constant 0.
- hwdata  out  32  write data.
- hrdata  in  32  read data.
- hready  in  1  combined bus ready.
- hresp  in  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11.

Behaviour:
- Reset (n_hreset low at a hclk edge): busy=0, done=0, err=0, words_done=0, hbusreq=0, haddr=0, htrans=IDLE, hwrite=0, hwdata=0, state=IDLE. Reset mid-job abandons the job immediately; any outstanding data phase is not completed.
- States: IDLE, RD_A, RD_D, WR_A, WR_D, RESP2, FIN.
- IDLE:
  - start with word_count=0: err cleared, done pulses next cycle, no bus activity, busy stays 0.
  - start with word_count>0: latch the addresses, count and word-aligned pointers; busy=1, hbusreq=1, err cleared, words_done=0; go to RD_A.
- RD_A: htrans=NONSEQ, hwrite=0, haddr=src pointer, only when hgrant=1; otherwise htrans=IDLE.
  - Address accepted at the edge where hgrant=1 and hready=1; go to RD_D and drive htrans=IDLE.
- RD_D: wait for hready=1.
  - hresp=OKAY: capture hrdata into the data buffer, go to WR_A.
- WR_A: same rules as RD_A with hwrite=1 and haddr=dst pointer; accepted, go to WR_D.
- WR_D: hwdata = buffer, held stable until hready=1.
  - OKAY: words_done+1, both pointers +4 (wrap at 2^32).
  - Remaining count 0: go to FIN; else go to RD_A.
- Non-OKAY hresp while hready=0 (first cycle of the two-cycle response): drive htrans=IDLE and go to RESP2. On hready=1:
  - ERROR: err=1, go to FIN; the failing word is not counted.
  - RETRY/SPLIT: re-enter the address state of the same transfer (RD_A or WR_A), same address, buffer preserved.
- FIN: done=1 for exactly one cycle; busy=0 and hbusreq=0 in the same cycle; return to IDLE.
- start while busy: ignored, no effect on latched job.
- Timing, zero-wait slave with grant held: 4 cycles per word; done pulses 1 cycle after the last write data phase completes.
- hwdata is don't-care outside WR_D but is held at its last value (no toggling).

Decomposition:
- Package ahb_master_pkg holds:
  - HTRANS_IDLE/NONSEQ and HRESP_OKAY/ERROR/RETRY/SPLIT codes;
  - HSIZE_WORD and HBURST_SINGLE;
  - the state enum typedef.
- Single module; no sub-module. Address/count datapath is small and lives inline.

Test Plan:
- Zero-wait ROM model 0x0000_0000 to SRAM model 0x2000_0000, start with word_count=4 and grant held -> 8 transfers alternating R/W at addresses 0x0,0x20000000,0x4,0x20000004...; done at cycle 17 after start; words_done=4; err=0; SRAM equals ROM contents.
- Same job, slave inserts 2 wait states on every data phase -> hwdata stable through waits; 8 cycles per word; identical final memory.
- hgrant deasserted for 3 cycles during WR_A of word 2 -> htrans=IDLE for those cycles; write issued on first granted cycle; no transfer lost or duplicated.
- Destination returns ERROR (two-cycle) on word 3 -> htrans=IDLE in second response cycle; err=1, done pulse; words_done=2; no further transfers.
- RETRY on read of word 1 -> same haddr reissued as NONSEQ; copy completes with words_done=word_count.
- start with word_count=0 -> done pulse next cycle, htrans stays IDLE; start pulsed mid-job -> ignored. n_hreset low mid-job -> all outputs at reset values on the next edge.
